mem_arbiter: RTL and testbench

- Shares the single-port unified instruction/data memory between the multicycle core (port C) and a DMA/loader master (port D).
- Each granted request is sequenced as one memory transaction with fixed latency. The block generates byte enables from the access mode and lane-aligns read data.
- The core FSM holds its request until `c_done`, so the arbiter acts as the core's memory wait-state source.

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_lane_align.sv | 41 ++++
 rtl/mem_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the unified-memory arbiter.
package mem_arb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    MODE_W = 2'b00,
    MODE_H = 2'b01,
    MODE_B = 2'b10
  } mem_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  typedef enum logic {
    PORT_C = 1'b0,
    PORT_D = 1'b1
  } port_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: byte enables, write replication, read shift/mask, misalignment.
module mem_lane_align
  import mem_arb_pkg::*;
(
  input  logic [1:0]        mode,
  input  logic [1:0]        lane,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [BE_W-1:0]   be_c,
  output logic [DATA_W-1:0] wdata_c,
  output logic [DATA_W-1:0] rdata_c,
  output logic              misaligned_c
);

  logic [DATA_W-1:0] shifted_c;

  // Lane selection per access size; unknown modes behave as word.
  always_comb begin
    shifted_c    = mem_rdata >> {lane, 3'b000};
    be_c         = 4'b1111;
    wdata_c      = wdata_in;
    rdata_c      = shifted_c;
    misaligned_c = (lane != 2'b00);
    case (mode)
      MODE_H: begin
        be_c         = lane[1] ? 4'b1100 : 4'b0011;
        wdata_c      = {2{wdata_in[15:0]}};
        rdata_c      = {16'h0000, shifted_c[15:0]};
        misaligned_c = lane[0];
      end
      MODE_B: begin
        be_c         = 4'b0001 << lane;
        wdata_c      = {4{wdata_in[7:0]}};
        rdata_c      = {24'h000000, shifted_c[7:0]};
        misaligned_c = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the single-port unified memory (core port C, DMA port D).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW        = 32,
  parameter int unsigned MEM_LAT   = 1,
  parameter int unsigned CORE_PRIO = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [AW-1:0]     c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  input  logic [1:0]        c_mode,
  output logic              c_done,
  output logic              c_err,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [AW-1:0]     d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [1:0]        d_mode,
  output logic              d_done,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [BE_W-1:0]   mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        state_q, state_d;
  port_t             grant_q, grant_d;
  port_t             last_q, last_d;
  logic              we_q, we_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        mode_q, mode_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              take_c;

  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              c_done_q, c_done_d, c_err_q, c_err_d;
  logic              d_done_q, d_done_d, d_err_q, d_err_d;
  logic [DATA_W-1:0] c_rdata_q, c_rdata_d, d_rdata_q, d_rdata_d;
  logic              issue_c, resp_c, capture_c;

  logic [BE_W-1:0]   be_c;
  logic [DATA_W-1:0] wdata_al_c;
  logic [DATA_W-1:0] rdata_al_c;
  logic              misaligned_c;

  // Single lane aligner; fed with the request being latched (IDLE) or the held one.
  mem_lane_align u_align (
    .mode         (mode_d),
    .lane         (addr_d[1:0]),
    .wdata_in     (wdata_d),
    .mem_rdata    (mem_rdata),
    .be_c         (be_c),
    .wdata_c      (wdata_al_c),
    .rdata_c      (rdata_al_c),
    .misaligned_c (misaligned_c)
  );

  // Arbitration in IDLE and latching of the winning request.
  always_comb begin
    take_c  = 1'b0;
    grant_d = grant_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mode_d  = mode_q;
    if (state_q == IDLE && (c_req || d_req)) begin
      take_c = 1'b1;
      if (c_req && d_req) begin
        grant_d = ((CORE_PRIO != 0) || (last_q == PORT_D)) ? PORT_C : PORT_D;
      end else begin
        grant_d = c_req ? PORT_C : PORT_D;
      end
      last_d = grant_d;
      if (grant_d == PORT_C) begin
        we_d    = c_we;
        addr_d  = c_addr;
        wdata_d = c_wdata;
        mode_d  = c_mode;
      end else begin
        we_d    = d_we;
        addr_d  = d_addr;
        wdata_d = d_wdata;
        mode_d  = d_mode;
      end
    end
  end

  // Next-state logic and latency counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (take_c) begin
          err_d   = misaligned_c;
          state_d = misaligned_c ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(MEM_LAT - 1);
        state_d = (MEM_LAT > 1) ? WAIT : RESP;
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_d == '0) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered outputs derived from the upcoming state.
  always_comb begin
    issue_c     = (state_d == ISSUE);
    resp_c      = (state_d == RESP);
    capture_c   = resp_c && (state_q != IDLE) && !we_d;
    mem_en_d    = issue_c;
    mem_we_d    = issue_c & we_d;
    mem_addr_d  = issue_c ? {addr_d[AW-1:2], 2'b00} : '0;
    mem_be_d    = issue_c ? be_c : '0;
    mem_wdata_d = issue_c ? wdata_al_c : '0;
    c_done_d    = resp_c && (grant_d == PORT_C);
    d_done_d    = resp_c && (grant_d == PORT_D);
    c_err_d     = c_done_d & err_d;
    d_err_d     = d_done_d & err_d;
    c_rdata_d   = (capture_c && grant_d == PORT_C) ? rdata_al_c : c_rdata_q;
    d_rdata_d   = (capture_c && grant_d == PORT_D) ? rdata_al_c : d_rdata_q;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Request latch, grant history and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_q     <= PORT_C;
      last_q      <= PORT_D;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mode_q      <= 2'b00;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      c_done_q    <= 1'b0;
      c_err_q     <= 1'b0;
      c_rdata_q   <= '0;
      d_done_q    <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      grant_q     <= grant_d;
      last_q      <= last_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mode_q      <= mode_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      c_done_q    <= c_done_d;
      c_err_q     <= c_err_d;
      c_rdata_q   <= c_rdata_d;
      d_done_q    <= d_done_d;
      d_err_q     <= d_err_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign c_done    = c_done_q;
  assign c_err     = c_err_q;
  assign c_rdata   = c_rdata_q;
  assign d_done    = d_done_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 is MEM_LAT=1/fixed priority, instance 1 is MEM_LAT=3/round-robin.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n     [2];
  logic        c_req     [2];
  logic        c_we      [2];
  logic [31:0] c_addr    [2];
  logic [31:0] c_wdata   [2];
  logic [1:0]  c_mode    [2];
  logic        c_done    [2];
  logic        c_err     [2];
  logic [31:0] c_rdata   [2];
  logic        d_req     [2];
  logic        d_we      [2];
  logic [31:0] d_addr    [2];
  logic [31:0] d_wdata   [2];
  logic [1:0]  d_mode    [2];
  logic        d_done    [2];
  logic        d_err     [2];
  logic [31:0] d_rdata   [2];
  logic        mem_en    [2];
  logic        mem_we    [2];
  logic [31:0] mem_addr  [2];
  logic [3:0]  mem_be    [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_arbiter #(
      .AW        (32),
      .MEM_LAT   ((g == 0) ? 1 : 3),
      .CORE_PRIO ((g == 0) ? 1 : 0)
    ) u_dut (
      .clk       (clk),
      .reset     (rst_n[g]),
      .c_req     (c_req[g]),
      .c_we      (c_we[g]),
      .c_addr    (c_addr[g]),
      .c_wdata   (c_wdata[g]),
      .c_mode    (c_mode[g]),
      .c_done    (c_done[g]),
      .c_err     (c_err[g]),
      .c_rdata   (c_rdata[g]),
      .d_req     (d_req[g]),
      .d_we      (d_we[g]),
      .d_addr    (d_addr[g]),
      .d_wdata   (d_wdata[g]),
      .d_mode    (d_mode[g]),
      .d_done    (d_done[g]),
      .d_err     (d_err[g]),
      .d_rdata   (d_rdata[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_be    (mem_be[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  // Observations of the last transaction.
  int          ob_en_cyc, ob_en_cnt, ob_done_cyc, ob_other;
  logic        ob_we, ob_err;
  logic [31:0] ob_addr, ob_wd, ob_rdata;
  logic [3:0]  ob_be;

  // Model: last read result per [instance][port].
  logic [31:0] mdl_rdata [2][2];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic m_misal(input logic [1:0] mode, input logic [31:0] a);
    if (mode == 2'b10) return 1'b0;
    if (mode == 2'b01) return a[0];
    return (a[1:0] != 2'b00);
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] mode, input logic [31:0] a);
    if (mode == 2'b10) return 4'(1 << a[1:0]);
    if (mode == 2'b01) return a[1] ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] mode, input logic [31:0] w);
    if (mode == 2'b10) return {4{w[7:0]}};
    if (mode == 2'b01) return {2{w[15:0]}};
    return w;
  endfunction

  function automatic logic [31:0] m_rd(input logic [1:0] mode, input logic [31:0] a,
                                       input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * a[1:0]);
    if (mode == 2'b10) return v & 32'h0000_00FF;
    if (mode == 2'b01) return v & 32'h0000_FFFF;
    return v;
  endfunction

  // Drives one request on port p of instance k and records what the DUT did.
  task automatic run_txn(input int k, input int p, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] mode,
                         input logic [31:0] rd);
    @(negedge clk);
    mem_rdata[k] = rd;
    if (p == 0) begin
      c_req[k] = 1'b1; c_we[k] = we; c_addr[k] = addr; c_wdata[k] = wdata; c_mode[k] = mode;
    end else begin
      d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wdata; d_mode[k] = mode;
    end
    ob_en_cyc = 0; ob_en_cnt = 0; ob_done_cyc = 0; ob_other = 0;
    ob_we = 1'b0; ob_err = 1'b0; ob_addr = '0; ob_wd = '0; ob_rdata = '0; ob_be = '0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (mem_en[k]) begin
        if (ob_en_cnt == 0) begin
          ob_en_cyc = n; ob_we = mem_we[k]; ob_addr = mem_addr[k];
          ob_be = mem_be[k]; ob_wd = mem_wdata[k];
        end
        ob_en_cnt++;
      end
      if ((p == 0) ? d_done[k] : c_done[k]) ob_other++;
      if ((p == 0) ? c_done[k] : d_done[k]) begin
        ob_done_cyc = n;
        ob_err      = (p == 0) ? c_err[k] : d_err[k];
        ob_rdata    = (p == 0) ? c_rdata[k] : d_rdata[k];
        break;
      end
      if (n == 1) begin
        // The held request must not be re-read once granted.
        if (p == 0) begin
          c_we[k] = ~we; c_addr[k] = $urandom; c_wdata[k] = $urandom; c_mode[k] = 2'($urandom);
        end else begin
          d_we[k] = ~we; d_addr[k] = $urandom; d_wdata[k] = $urandom; d_mode[k] = 2'($urandom);
        end
      end
    end
    c_req[k] = 1'b0;
    d_req[k] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset(input int k);
    @(negedge clk);
    c_req[k] = 1'b0; d_req[k] = 1'b0;
    rst_n[k] = 1'b0;
    @(negedge clk);
    rst_n[k] = 1'b1;
    mdl_rdata[k][0] = '0;
    mdl_rdata[k][1] = '0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; c_req[k] = 1'b0; c_we[k] = 1'b0; c_addr[k] = '0; c_wdata[k] = '0;
      c_mode[k] = 2'b00; d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
      d_mode[k] = 2'b00; mem_rdata[k] = 32'hFFFF_FFFF;
      mdl_rdata[k][0] = '0; mdl_rdata[k][1] = '0;
    end
    #12;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({mem_en[k], mem_we[k], mem_addr[k], mem_be[k], mem_wdata[k], c_done[k], c_err[k],
           c_rdata[k], d_done[k], d_err[k], d_rdata[k]} !== '0) begin
        n_errors++;
        $display("FAIL reset_outputs[%0d]: mem_en=%b addr=%h be=%h c_rdata=%h d_rdata=%h want all 0",
                 k, mem_en[k], mem_addr[k], mem_be[k], c_rdata[k], d_rdata[k]);
      end
    end
    @(negedge clk);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({mem_en[k], c_done[k], d_done[k]} !== 3'b000) begin
        n_errors++;
        $display("FAIL idle_quiet[%0d]: en/c_done/d_done=%b want 000", k,
                 {mem_en[k], c_done[k], d_done[k]});
      end
    end
  endtask

  task automatic test_store_word();
    run_txn(0, 0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 2'b00, 32'h0);
    n_checks++;
    if (ob_en_cyc !== 1 || ob_en_cnt !== 1) begin
      n_errors++; $display("FAIL sw_en: cycle %0d count %0d want cycle 1 count 1", ob_en_cyc, ob_en_cnt);
    end
    n_checks++;
    if ({ob_we, ob_be} !== 5'b1_1111) begin
      n_errors++; $display("FAIL sw_we_be: got we=%b be=%b want we=1 be=1111", ob_we, ob_be);
    end
    n_checks++;
    if (ob_addr !== 32'h0000_0100 || ob_wd !== 32'hDEAD_BEEF) begin
      n_errors++; $display("FAIL sw_addr_data: got %h/%h want 00000100/deadbeef", ob_addr, ob_wd);
    end
    n_checks++;
    if (ob_done_cyc !== 2 || ob_other !== 0) begin
      n_errors++; $display("FAIL sw_done: c_done cycle %0d d_done pulses %0d want 2 and 0", ob_done_cyc, ob_other);
    end
    n_checks++;
    if (ob_err !== 1'b0 || ob_rdata !== mdl_rdata[0][0]) begin
      n_errors++; $display("FAIL sw_resp: err=%b rdata=%h want 0/%h", ob_err, ob_rdata, mdl_rdata[0][0]);
    end
  endtask

  task automatic test_store_byte();
    run_txn(0, 0, 1'b1, 32'h0000_0103, 32'h0000_00AB, 2'b10, 32'h0);
    n_checks++;
    if (ob_be !== 4'b1000) begin
      n_errors++; $display("FAIL sb_be: got %b want 1000", ob_be);
    end
    n_checks++;
    if (ob_wd !== 32'hABAB_ABAB || ob_addr !== 32'h0000_0100) begin
      n_errors++; $display("FAIL sb_data_addr: got %h/%h want ababab ab/00000100", ob_wd, ob_addr);
    end
    n_checks++;
    if (ob_done_cyc !== 2) begin
      n_errors++; $display("FAIL sb_done: cycle %0d want 2", ob_done_cyc);
    end
  endtask

  task automatic test_load_half_lat3();
    run_txn(1, 0, 1'b0, 32'h0000_0102, 32'h0, 2'b01, 32'h1234_ABCD);
    mdl_rdata[1][0] = 32'h0000_1234;
    n_checks++;
    if (ob_en_cyc !== 1 || ob_en_cnt !== 1 || ob_we !== 1'b0) begin
      n_errors++; $display("FAIL lh_en: cycle %0d count %0d we %b want 1/1/0", ob_en_cyc, ob_en_cnt, ob_we);
    end
    n_checks++;
    if (ob_be !== 4'b1100) begin
      n_errors++; $display("FAIL lh_be: got %b want 1100", ob_be);
    end
    n_checks++;
    if (ob_done_cyc !== 4) begin
      n_errors++; $display("FAIL lh_done: cycle %0d want 4", ob_done_cyc);
    end
    n_checks++;
    if (ob_rdata !== mdl_rdata[1][0]) begin
      n_errors++; $display("FAIL lh_rdata: got %h want %h", ob_rdata, mdl_rdata[1][0]);
    end
  endtask

  task automatic test_misaligned();
    run_txn(0, 0, 1'b0, 32'h0000_0104, 32'h0, 2'b00, 32'hCAFE_F00D);
    mdl_rdata[0][0] = 32'hCAFE_F00D;
    n_checks++;
    if (ob_rdata !== mdl_rdata[0][0]) begin
      n_errors++; $display("FAIL lw_rdata: got %h want %h", ob_rdata, mdl_rdata[0][0]);
    end
    run_txn(0, 0, 1'b0, 32'h0000_0102, 32'h0, 2'b00, 32'h1111_2222);
    n_checks++;
    if (ob_en_cnt !== 0) begin
      n_errors++; $display("FAIL mis_no_access: mem_en pulses %0d want 0", ob_en_cnt);
    end
    n_checks++;
    if (ob_done_cyc !== 1 || ob_err !== 1'b1) begin
      n_errors++; $display("FAIL mis_done_err: cycle %0d err %b want 1/1", ob_done_cyc, ob_err);
    end
    n_checks++;
    if (ob_rdata !== mdl_rdata[0][0]) begin
      n_errors++; $display("FAIL mis_rdata_held: got %h want %h", ob_rdata, mdl_rdata[0][0]);
    end
  endtask

  task automatic test_arbitration(input int k);
    int exp_seq [4];
    int obs_seq [4];
    int cnt;
    int last;
    pulse_reset(k);
    last = 1;
    for (int i = 0; i < 4; i++) begin
      exp_seq[i] = (k == 0 || last == 1) ? 0 : 1;
      last = exp_seq[i];
      obs_seq[i] = -1;
    end
    @(negedge clk);
    mem_rdata[k] = 32'h0BAD_C0DE;
    c_req[k] = 1'b1; c_we[k] = 1'b0; c_addr[k] = 32'h10; c_mode[k] = 2'b00;
    d_req[k] = 1'b1; d_we[k] = 1'b0; d_addr[k] = 32'h20; d_mode[k] = 2'b00;
    cnt = 0;
    for (int n = 0; n < 80 && cnt < 4; n++) begin
      @(posedge clk); #1;
      if (c_done[k] && d_done[k]) begin
        n_checks++; n_errors++;
        $display("FAIL arb_both_done[%0d]: both done at once, want one", k);
      end
      if (c_done[k]) begin obs_seq[cnt] = 0; cnt++; end
      else if (d_done[k]) begin obs_seq[cnt] = 1; cnt++; end
    end
    c_req[k] = 1'b0; d_req[k] = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (cnt !== 4) begin
      n_errors++; $display("FAIL arb_count[%0d]: %0d grants want 4", k, cnt);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (obs_seq[i] !== exp_seq[i]) begin
        n_errors++;
        $display("FAIL arb_order[%0d] grant %0d: port %0d want %0d (0=C,1=D)", k, i, obs_seq[i], exp_seq[i]);
      end
      mdl_rdata[k][exp_seq[i]] = 32'h0BAD_C0DE;
    end
  endtask

  task automatic test_reset_abort();
    int bad;
    @(negedge clk);
    mem_rdata[1] = 32'h7777_8888;
    c_req[1] = 1'b1; c_we[1] = 1'b0; c_addr[1] = 32'h200; c_mode[1] = 2'b00;
    @(posedge clk); #1;
    n_checks++;
    if (mem_en[1] !== 1'b1) begin
      n_errors++; $display("FAIL abort_issue: mem_en=%b want 1", mem_en[1]);
    end
    @(posedge clk); #1;
    rst_n[1] = 1'b0;
    #1;
    c_req[1] = 1'b0;
    n_checks++;
    if ({mem_en[1], mem_we[1], mem_addr[1], mem_be[1], mem_wdata[1], c_done[1], c_err[1],
         c_rdata[1], d_done[1], d_err[1], d_rdata[1]} !== '0) begin
      n_errors++;
      $display("FAIL abort_outputs: mem_en=%b c_done=%b c_rdata=%h d_rdata=%h want all 0",
               mem_en[1], c_done[1], c_rdata[1], d_rdata[1]);
    end
    mdl_rdata[1][0] = '0; mdl_rdata[1][1] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n[1] = 1'b1;
    bad = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (c_done[1] || d_done[1] || mem_en[1]) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_errors++; $display("FAIL abort_no_done: %0d active cycles after reset want 0", bad);
    end
    run_txn(1, 0, 1'b0, 32'h0000_0040, 32'h0, 2'b00, 32'h55AA_33CC);
    mdl_rdata[1][0] = 32'h55AA_33CC;
    n_checks++;
    if (ob_done_cyc !== 4 || ob_rdata !== mdl_rdata[1][0]) begin
      n_errors++;
      $display("FAIL abort_recover: done cycle %0d rdata %h want 4/%h", ob_done_cyc, ob_rdata, mdl_rdata[1][0]);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 2; k++) begin
      for (int t = 0; t < 40; t++) begin
        int          p;
        logic        we, mis;
        logic [1:0]  mode;
        logic [31:0] addr, wdata, rd;
        p = int'($urandom_range(1, 0));
        we = 1'($urandom);
        mode = 2'($urandom);
        addr = $urandom;
        wdata = $urandom;
        rd = $urandom;
        mis = m_misal(mode, addr);
        run_txn(k, p, we, addr, wdata, mode, rd);
        if (!we && !mis) mdl_rdata[k][p] = m_rd(mode, addr, rd);
        n_checks++;
        if (ob_done_cyc !== (mis ? 1 : 1 + lat_of(k)) || ob_err !== mis || ob_other !== 0) begin
          n_errors++;
          $display("FAIL rnd_done[%0d.%0d]: cycle %0d err %b other %0d want %0d/%b/0",
                   k, t, ob_done_cyc, ob_err, ob_other, mis ? 1 : 1 + lat_of(k), mis);
        end
        n_checks++;
        if (ob_en_cnt !== (mis ? 0 : 1)) begin
          n_errors++; $display("FAIL rnd_en[%0d.%0d]: %0d pulses want %0d", k, t, ob_en_cnt, mis ? 0 : 1);
        end
        if (!mis) begin
          n_checks++;
          if (ob_we !== we || ob_addr !== {addr[31:2], 2'b00} || ob_be !== m_be(mode, addr) ||
              ob_wd !== m_wd(mode, wdata)) begin
            n_errors++;
            $display("FAIL rnd_mem[%0d.%0d]: we=%b addr=%h be=%b wd=%h want %b/%h/%b/%h", k, t,
                     ob_we, ob_addr, ob_be, ob_wd, we, {addr[31:2], 2'b00}, m_be(mode, addr),
                     m_wd(mode, wdata));
          end
        end
        n_checks++;
        if (ob_rdata !== mdl_rdata[k][p]) begin
          n_errors++;
          $display("FAIL rnd_rdata[%0d.%0d]: got %h want %h (mode %b addr %h)", k, t, ob_rdata,
                   mdl_rdata[k][p], mode, addr);
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_store_word();
    test_store_byte();
    test_load_half_lat3();
    test_misaligned();
    test_arbitration(0);
    test_arbitration(1);
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

endmodule
